// File: rtl/reg_wb_pkg.sv
// Shared widths, source indices and the holding-slot record for the
// register-file writeback arbiter.
package reg_wb_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREG   = 1 << ADDR_W;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
    data_t data;
  } slot_t;

  function automatic logic [NREG-1:0] onehot(input addr_t a, input logic en);
    logic [NREG-1:0] m;
    m    = '0;
    m[a] = en;
    return m;
  endfunction
endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Writeback bus between the two sources, the reg_file write port and
// the decode/stall logic.
interface reg_wb_arbiter_if;
  import reg_wb_pkg::*;

  logic            busywait;
  logic            alu_valid;
  addr_t           alu_addr;
  data_t           alu_data;
  logic            alu_ready;
  logic            mem_valid;
  addr_t           mem_addr;
  data_t           mem_data;
  logic            mem_ready;
  logic            writeen;
  addr_t           inaddr;
  data_t           in_data;
  logic [NREG-1:0] pending_mask;
  logic            idle;

  modport master (
    output busywait, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready, writeen, inaddr, in_data, pending_mask, idle
  );

  modport slave (
    input  busywait, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready, writeen, inaddr, in_data, pending_mask, idle
  );
endinterface

// File: rtl/reg_wb_slot.sv
// One-entry holding register. A grant while empty consumes the incoming
// request directly, so it is never stored.
module reg_wb_slot
  import reg_wb_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  valid,
  input  addr_t addr,
  input  data_t data,
  input  logic  grant,
  output logic  ready,
  output slot_t slot
);

  assign ready = !slot.valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (slot.valid) begin
      if (grant) slot.valid <= 1'b0;
    end else if (valid && !grant) begin
      slot <= '{valid: 1'b1, addr: addr, data: data};
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single reg_file write port.
// Define REG_WB_RR_EN for round-robin between sources on differing addresses.
module reg_wb_arbiter
  import reg_wb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  reg_wb_arbiter_if.slave  bus
);

  slot_t alu_slot, mem_slot;
  logic  alu_cand, mem_cand, alu_first, alu_older;
  logic  any_grant, grant_src, grant_alu, grant_mem;
  logic  alu_store, mem_store, contend_diff;
  addr_t alu_c_addr, mem_c_addr, wr_addr;
  data_t alu_c_data, mem_c_data, wr_data;
  logic  wr_en;
`ifdef REG_WB_RR_EN
  logic  last_src;
`endif

  reg_wb_slot u_alu_slot (
    .clk(clk), .rst(rst), .valid(bus.alu_valid), .addr(bus.alu_addr),
    .data(bus.alu_data), .grant(grant_alu), .ready(bus.alu_ready), .slot(alu_slot)
  );

  reg_wb_slot u_mem_slot (
    .clk(clk), .rst(rst), .valid(bus.mem_valid), .addr(bus.mem_addr),
    .data(bus.mem_data), .grant(grant_mem), .ready(bus.mem_ready), .slot(mem_slot)
  );

  // A candidate is the held slot, or the incoming request when the slot is empty.
  always_comb begin
    alu_cand   = alu_slot.valid || bus.alu_valid;
    mem_cand   = mem_slot.valid || bus.mem_valid;
    alu_c_addr = alu_slot.valid ? alu_slot.addr : bus.alu_addr;
    alu_c_data = alu_slot.valid ? alu_slot.data : bus.alu_data;
    mem_c_addr = mem_slot.valid ? mem_slot.addr : bus.mem_addr;
    mem_c_data = mem_slot.valid ? mem_slot.data : bus.mem_data;

    if (alu_slot.valid && mem_slot.valid) alu_first = alu_older;
    else if (mem_slot.valid)              alu_first = 1'b0;
    else                                  alu_first = 1'b1;

    contend_diff = alu_cand && mem_cand && (alu_c_addr != mem_c_addr);
    any_grant    = 1'b0;
    grant_src    = SRC_MEM;
    if (!bus.busywait) begin
      if (alu_cand && mem_cand) begin
        any_grant = 1'b1;
        if (!contend_diff)
          grant_src = alu_first ? SRC_ALU : SRC_MEM;
        else
`ifdef REG_WB_RR_EN
          grant_src = (last_src == SRC_ALU) ? SRC_MEM : SRC_ALU;
`else
          grant_src = SRC_MEM;
`endif
      end else if (alu_cand) begin
        any_grant = 1'b1;
        grant_src = SRC_ALU;
      end else if (mem_cand) begin
        any_grant = 1'b1;
        grant_src = SRC_MEM;
      end
    end
    grant_alu = any_grant && (grant_src == SRC_ALU);
    grant_mem = any_grant && (grant_src == SRC_MEM);
    alu_store = bus.alu_valid && bus.alu_ready && !grant_alu;
    mem_store = bus.mem_valid && bus.mem_ready && !grant_mem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       alu_older <= 1'b0;
    else if (alu_store && mem_store) alu_older <= 1'b1;
    else if (alu_store)            alu_older <= 1'b0;
    else if (mem_store)            alu_older <= 1'b1;
  end

`ifdef REG_WB_RR_EN
  // Reset value points at ALU so MEM wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              last_src <= SRC_ALU;
    else if (!bus.busywait && contend_diff) last_src <= grant_src;
  end
`endif

  // Output stage holds still while the memory stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (!bus.busywait) begin
      wr_en <= any_grant;
      if (any_grant) begin
        wr_addr <= (grant_src == SRC_MEM) ? mem_c_addr : alu_c_addr;
        wr_data <= (grant_src == SRC_MEM) ? mem_c_data : alu_c_data;
      end
    end
  end

  assign bus.writeen      = wr_en;
  assign bus.inaddr       = wr_addr;
  assign bus.in_data      = wr_data;
  assign bus.pending_mask = onehot(alu_slot.addr, alu_slot.valid)
                          | onehot(mem_slot.addr, mem_slot.valid)
                          | onehot(wr_addr, wr_en);
  assign bus.idle         = bus.alu_ready && bus.mem_ready && !wr_en;

endmodule
